// File: rtl/peripheral_wb_burst_master_if.sv
// Command, write/read stream and Wishbone master signals
// bundled for peripheral_wb_burst_master.
interface peripheral_wb_burst_master_if #(
  parameter int DW   = 32,
  parameter int AW   = 8,
  parameter int LENW = 8
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_we_i;
  logic [AW-1:0]   cmd_adr_i;
  logic [LENW-1:0] cmd_len_i;

  logic            wdata_valid_i;
  logic [DW-1:0]   wdata_i;
  logic            wdata_ready_o;

  logic            rdata_valid_o;
  logic [DW-1:0]   rdata_o;
  logic            rdata_ready_i;

  logic            done_o;
  logic            err_o;

  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [3:0]      wb_sel_o;
  logic            wb_we_o;
  logic [1:0]      wb_bte_o;
  logic [2:0]      wb_cti_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i,
    input  wdata_valid_i, wdata_i, rdata_ready_i,
    input  wb_ack_i, wb_err_i, wb_dat_i,
    output cmd_ready_o, wdata_ready_o,
    output rdata_valid_o, rdata_o, done_o, err_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    output wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i,
    output wdata_valid_i, wdata_i, rdata_ready_i,
    output wb_ack_i, wb_err_i, wb_dat_i,
    input  cmd_ready_o, wdata_ready_o,
    input  rdata_valid_o, rdata_o, done_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    input  wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/peripheral_wb_burst_master.sv
// Command-driven Wishbone B3 incrementing burst master.
// Optional stall watchdog: define WB_BURST_TIMEOUT_EN.
module peripheral_wb_burst_master #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 255
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  peripheral_wb_burst_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   adr_q;
  logic [AW-1:0]   adr_d;
  logic [LENW-1:0] cnt_q;
  logic [LENW-1:0] cnt_d;
  logic            we_q;
  logic            single_q;
  logic            fin_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;

  logic in_burst;
  logic last;
  logic rd_room;
  logic stb;
  logic ack;
  logic abort;
  logic to_hit;

  assign in_burst = (state_q == S_BURST);
  assign last     = (cnt_q == '0);
  assign rd_room  = ~rvalid_q | bus.rdata_ready_i;
  assign adr_d    = adr_q + 1'b1;
  assign cnt_d    = cnt_q - 1'b1;

  // fin_q: read burst fully acked, waiting for the last beat to drain
  assign stb   = in_burst & ~fin_q &
                 (we_q ? bus.wdata_valid_i : rd_room);
  assign ack   = stb & bus.wb_ack_i & ~bus.wb_err_i;
  assign abort = stb & (bus.wb_err_i | to_hit);

`ifdef WB_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wdog_q;

  assign to_hit = stb & ~bus.wb_ack_i & ~bus.wb_err_i &
                  (wdog_q == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wdog_q <= '0;
    end else if (!in_burst || ack) begin
      wdog_q <= '0;
    end else if (stb && !bus.wb_err_i) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign to_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      single_q <= 1'b0;
      fin_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (ack && !we_q) begin
        rdata_q  <= bus.wb_dat_i;
        rvalid_q <= 1'b1;
      end else if (rvalid_q && bus.rdata_ready_i) begin
        rvalid_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          fin_q <= 1'b0;
          if (bus.cmd_valid_i) begin
            adr_q    <= bus.cmd_adr_i;
            cnt_q    <= bus.cmd_len_i;
            we_q     <= bus.cmd_we_i;
            single_q <= (bus.cmd_len_i == '0);
            state_q  <= S_BURST;
          end
        end
        S_BURST: begin
          if (abort) begin
            state_q <= S_ERR;
          end else if (ack) begin
            adr_q <= adr_d;
            if (!last) begin
              cnt_q <= cnt_d;
            end else if (we_q) begin
              state_q <= S_DONE;
            end else begin
              fin_q <= 1'b1;
            end
          end else if (fin_q && rd_room) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          fin_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          fin_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o   = (state_q == S_IDLE);
  assign bus.wdata_ready_o = ack & we_q;
  assign bus.rdata_valid_o = rvalid_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.err_o         = (state_q == S_ERR);

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = (in_burst && we_q) ? bus.wdata_i : '0;
  assign bus.wb_sel_o = in_burst ? 4'hF : 4'h0;
  assign bus.wb_we_o  = in_burst & we_q;
  assign bus.wb_bte_o = 2'b00;
  assign bus.wb_cyc_o = in_burst;
  assign bus.wb_stb_o = stb;

  always_comb begin
    bus.wb_cti_o = 3'b000;
    if (in_burst && !single_q) begin
      bus.wb_cti_o = last ? 3'b111 : 3'b010;
    end
  end

endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// Directed bench for peripheral_wb_burst_master with a
// behavioural single-port RAM slave.
module tb_peripheral_wb_burst_master;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic        ack_en;
  logic        err_en;
  logic [7:0]  err_adr;
  logic [31:0] mem [256];

  peripheral_wb_burst_master_if #(
    .DW(32), .AW(8), .LENW(8)
  ) bus ();

  peripheral_wb_burst_master #(
    .DW(32), .AW(8), .LENW(8), .TIMEOUT(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.wb_ack_i = ack_en & bus.wb_stb_o;
  assign bus.wb_err_i = err_en & bus.wb_stb_o &
                        (bus.wb_adr_o == err_adr);
  assign bus.wb_dat_i = mem[bus.wb_adr_o];

  always @(posedge clk) begin
    if (bus.wb_stb_o && bus.wb_ack_i && !bus.wb_err_i &&
        bus.wb_we_o)
      mem[bus.wb_adr_o] <= bus.wb_dat_o;
  end

  task automatic idle_inputs;
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_we_i      = 1'b0;
    bus.cmd_adr_i     = '0;
    bus.cmd_len_i     = '0;
    bus.wdata_valid_i = 1'b0;
    bus.wdata_i       = '0;
    bus.rdata_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    ack_en  = 1'b1;
    err_en  = 1'b0;
    err_adr = 8'h00;
    idle_inputs();
    #12;
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got=%b want=1",
               bus.cmd_ready_o);
    end
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
         bus.wb_sel_o, bus.wb_cti_o, bus.wb_bte_o,
         bus.wb_adr_o, bus.wb_dat_o, bus.rdata_valid_o,
         bus.rdata_o, bus.done_o, bus.err_o,
         bus.wdata_ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cyc=%b stb=%b adr=%h dat=%h rdata=%h done=%b err=%b want all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o,
               bus.wb_dat_o, bus.rdata_o, bus.done_o,
               bus.err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_write(input logic [7:0] a,
                           input logic [7:0] len,
                           input logic [31:0] d0,
                           input string tag);
    logic [7:0]  ea;
    logic [2:0]  ec;
    logic [31:0] ed;
    @(negedge clk);
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_we_i      = 1'b1;
    bus.cmd_adr_i     = a;
    bus.cmd_len_i     = len;
    bus.wdata_valid_i = 1'b1;
    bus.wdata_i       = d0;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + 8'(i);
      ed = d0 + 32'(i);
      if (len == 8'd0)       ec = 3'b000;
      else if (i == int'(len)) ec = 3'b111;
      else                   ec = 3'b010;
      @(negedge clk);
      checks++;
      if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
           bus.wb_sel_o, bus.wb_adr_o, bus.wb_cti_o,
           bus.wb_dat_o, bus.wdata_ready_o} !==
          {3'b111, 4'hF, ea, ec, ed, 1'b1}) begin
        errors++;
        $display("FAIL %s_beat%0d got cyc=%b stb=%b adr=%h cti=%b dat=%h rdy=%b want adr=%h cti=%b dat=%h",
                 tag, i, bus.wb_cyc_o, bus.wb_stb_o,
                 bus.wb_adr_o, bus.wb_cti_o, bus.wb_dat_o,
                 bus.wdata_ready_o, ea, ec, ed);
      end
      @(posedge clk);
      #1;
      if (i == int'(len)) bus.wdata_valid_i = 1'b0;
      else                bus.wdata_i = d0 + 32'(i + 1);
    end
    @(negedge clk);
    checks++;
    if ({bus.done_o, bus.err_o, bus.wb_cyc_o} !== 3'b100)
    begin
      errors++;
      $display("FAIL %s_done got done=%b err=%b cyc=%b want 1 0 0",
               tag, bus.done_o, bus.err_o, bus.wb_cyc_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.done_o, bus.cmd_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL %s_idle got done=%b ready=%b want 0 1",
               tag, bus.done_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_write;
    run_write(8'h10, 8'd3, 32'hA0, "write");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h10 + i] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL write_mem%0d got=%h want=%h", i,
                 mem[8'h10 + i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_read;
    logic [31:0] got[$];
    bit dn = 1'b0;
    bit bad_stb = 1'b0;
    bit rv_at_done = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 8'h10;
    bus.cmd_len_i   = 8'd3;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    for (int n = 0; n < 60 && !dn; n++) begin
      bus.rdata_ready_i = 1'(n % 2);
      @(negedge clk);
      if (bus.wb_stb_o && bus.rdata_valid_o &&
          !bus.rdata_ready_i)
        bad_stb = 1'b1;
      if (bus.rdata_valid_o && bus.rdata_ready_i)
        got.push_back(bus.rdata_o);
      if (bus.done_o) begin
        dn = 1'b1;
        rv_at_done = bus.rdata_valid_o;
      end
      @(posedge clk);
      #1;
    end
    bus.rdata_ready_i = 1'b0;
    checks++;
    if (dn !== 1'b1 || rv_at_done !== 1'b0) begin
      errors++;
      $display("FAIL read_done got done=%b rvalid=%b want 1 0",
               dn, rv_at_done);
    end
    checks++;
    if (bad_stb !== 1'b0) begin
      errors++;
      $display("FAIL read_stb_full got=1 want=0");
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL read_count got=%0d want=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL read_beat%0d got=%h want=%h", i,
                 got[i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_wrap;
    run_write(8'hFF, 8'd0, 32'hB0, "single");
    run_write(8'hFE, 8'd2, 32'hC0, "wrap");
    checks++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !==
        {32'hC0, 32'hC1, 32'hC2}) begin
      errors++;
      $display("FAIL wrap_mem got=%h %h %h want=c0 c1 c2",
               mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
  endtask

  task automatic test_error;
    logic [31:0] got[$];
    int errs = 0;
    bit dn = 1'b0;
    bit cyc_bad = 1'b0;
    @(negedge clk);
    err_en  = 1'b1;
    err_adr = 8'h12;
    bus.rdata_ready_i = 1'b1;
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_we_i      = 1'b0;
    bus.cmd_adr_i     = 8'h10;
    bus.cmd_len_i     = 8'd7;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.rdata_valid_o && bus.rdata_ready_i)
        got.push_back(bus.rdata_o);
      if (bus.err_o) begin
        errs++;
        if (bus.wb_cyc_o || bus.wb_stb_o) cyc_bad = 1'b1;
      end
      if (bus.done_o) dn = 1'b1;
    end
    err_en = 1'b0;
    bus.rdata_ready_i = 1'b0;
    checks++;
    if (errs != 1) begin
      errors++;
      $display("FAIL err_pulse got=%0d want=1", errs);
    end
    checks++;
    if (cyc_bad !== 1'b0 || dn !== 1'b0) begin
      errors++;
      $display("FAIL err_abort got cyc_bad=%b done=%b want 0 0",
               cyc_bad, dn);
    end
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL err_count got=%0d want=2", got.size());
    end else begin
      checks++;
      if ({got[0], got[1]} !== {32'hA0, 32'hA1}) begin
        errors++;
        $display("FAIL err_data got=%h %h want=a0 a1",
                 got[0], got[1]);
      end
    end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL err_idle got=%b want=1", bus.cmd_ready_o);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_we_i      = 1'b1;
    bus.cmd_adr_i     = 8'h30;
    bus.cmd_len_i     = 8'd5;
    bus.wdata_valid_i = 1'b1;
    bus.wdata_i       = 32'hD0;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    @(posedge clk);
    #1 bus.wdata_i = 32'hD1;
    @(negedge clk);
    checks++;
    if ({bus.wb_stb_o, bus.wb_adr_o} !== {1'b1, 8'h31}) begin
      errors++;
      $display("FAIL midrst_beat2 got stb=%b adr=%h want 1 31",
               bus.wb_stb_o, bus.wb_adr_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready_o, bus.wb_cyc_o, bus.wb_stb_o,
         bus.wb_adr_o, bus.wb_dat_o, bus.wb_cti_o,
         bus.done_o, bus.err_o} !== {1'b1, 1'b0, 1'b0,
         8'h00, 32'h0, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b cyc=%b stb=%b adr=%h done=%b err=%b want 1 0 0 00 0 0",
               bus.cmd_ready_o, bus.wb_cyc_o, bus.wb_stb_o,
               bus.wb_adr_o, bus.done_o, bus.err_o);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_write(8'h40, 8'd1, 32'hE0, "after_rst");
    checks++;
    if ({mem[8'h40], mem[8'h41]} !== {32'hE0, 32'hE1}) begin
      errors++;
      $display("FAIL after_rst_mem got=%h %h want=e0 e1",
               mem[8'h40], mem[8'h41]);
    end
  endtask

`ifdef WB_BURST_TIMEOUT_EN
  task automatic test_timeout;
    int first = -1;
    int errn  = -1;
    @(negedge clk);
    ack_en = 1'b0;
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_we_i      = 1'b1;
    bus.cmd_adr_i     = 8'h50;
    bus.cmd_len_i     = 8'd3;
    bus.wdata_valid_i = 1'b1;
    bus.wdata_i       = 32'hF0;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    for (int n = 0; n < 40 && errn < 0; n++) begin
      @(negedge clk);
      if (bus.wb_stb_o && first < 0) first = n;
      if (bus.err_o) begin
        errn = n;
        checks++;
        if (bus.wb_cyc_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_cyc got=%b want=0",
                   bus.wb_cyc_o);
        end
      end
    end
    bus.wdata_valid_i = 1'b0;
    ack_en = 1'b1;
    checks++;
    if (errn < 0 || first < 0 || errn - first != 16) begin
      errors++;
      $display("FAIL timeout_delay got=%0d want=16",
               errn - first);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle got=%b want=1",
               bus.cmd_ready_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_error();
    test_reset_mid();
`ifdef WB_BURST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
